// File: rtl/irom_arbiter.sv
// Arbitrates the asynchronous-read instruction ROM between the fetch stage (IF)
// and the load/store unit (LS), with registered responses and configurable wait states.
module irom_arbiter #(
    parameter int          ADDR_BITS   = 20,
    parameter logic [31:0] BASE_ADDR   = 32'h1c000000,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_req_valid,
    output logic                 if_req_ready,
    input  logic [31:0]          if_req_addr,
    output logic                 if_resp_valid,
    input  logic                 if_resp_ready,
    output logic [31:0]          if_resp_data,
    output logic                 if_resp_err,
    input  logic                 ls_req_valid,
    output logic                 ls_req_ready,
    input  logic [31:0]          ls_req_addr,
    output logic                 ls_resp_valid,
    input  logic                 ls_resp_ready,
    output logic [31:0]          ls_resp_data,
    output logic                 ls_resp_err,
    output logic [ADDR_BITS-1:0] rom_a,
    input  logic [31:0]          rom_spo
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
    typedef enum logic {GNT_IF, GNT_LS} gnt_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

    state_t               state_q, state_d;
    gnt_t                 gnt_q, gnt_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic [ADDR_BITS-1:0] rom_a_q, rom_a_d;
    logic [31:0]          data_q, data_d;
    logic                 if_valid_q, if_valid_d;
    logic                 ls_valid_q, ls_valid_d;

    logic        sel_if, sel_ls;
    logic [31:0] req_addr, offset, index;
    logic        req_err;

    // gnt_q doubles as last_grant: on a tie the requester not served last wins.
    assign sel_if = if_req_valid & (~ls_req_valid | (gnt_q == GNT_LS));
    assign sel_ls = ls_req_valid & (~if_req_valid | (gnt_q == GNT_IF));

    assign if_req_ready = (state_q == S_IDLE) & sel_if;
    assign ls_req_ready = (state_q == S_IDLE) & sel_ls;

    assign req_addr = sel_ls ? ls_req_addr : if_req_addr;
    assign offset   = req_addr - BASE_ADDR;
    assign index    = offset >> 2;
    assign req_err  = (req_addr[1:0] != 2'b00) | (req_addr < BASE_ADDR) |
                      ((index >> ADDR_BITS) != 32'd0);

    always_comb begin
        // NOTE: every _d gets its current value first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        gnt_d      = gnt_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        rom_a_d    = rom_a_q;
        data_d     = data_q;
        if_valid_d = if_valid_q;
        ls_valid_d = ls_valid_q;
        case (state_q)
            S_IDLE: begin
                if (sel_if || sel_ls) begin
                    gnt_d   = sel_ls ? GNT_LS : GNT_IF;
                    err_d   = req_err;
                    rom_a_d = req_err ? '0 : index[ADDR_BITS-1:0];
                    cnt_d   = CNT_INIT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    data_d     = err_q ? 32'd0 : rom_spo;
                    if_valid_d = (gnt_q == GNT_IF);
                    ls_valid_d = (gnt_q == GNT_LS);
                    state_d    = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if ((if_valid_q && if_resp_ready) || (ls_valid_q && ls_resp_ready)) begin
                    if_valid_d = 1'b0;
                    ls_valid_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            gnt_q      <= GNT_LS;
            cnt_q      <= 4'd0;
            err_q      <= 1'b0;
            rom_a_q    <= '0;
            data_q     <= 32'd0;
            if_valid_q <= 1'b0;
            ls_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            rom_a_q    <= rom_a_d;
            data_q     <= data_d;
            if_valid_q <= if_valid_d;
            ls_valid_q <= ls_valid_d;
        end
    end

    assign rom_a         = rom_a_q;
    assign if_resp_valid = if_valid_q;
    assign ls_resp_valid = ls_valid_q;
    assign if_resp_data  = data_q;
    assign ls_resp_data  = data_q;
    assign if_resp_err   = err_q;
    assign ls_resp_err   = err_q;

endmodule
